// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared sizes, FSM states and one-hot/index helpers for the 16:1 mux arbiter
package mux_arb_pkg;
  localparam int N_REQ = 16;
  localparam int SEL_W = 4;
  typedef enum logic {IDLE, GRANT} state_t;
  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] i);
    return N_REQ'(1) << i;
  endfunction
  function automatic logic [SEL_W-1:0] lowest_set(input logic [N_REQ-1:0] v);
    logic [SEL_W-1:0] r;
    r = '0;
    for (int i = N_REQ - 1; i >= 0; i--) if (v[i]) r = SEL_W'(i);
    return r;
  endfunction
endpackage

// File: rtl/mux16_rr_arbiter_rr_pick.sv
// rr_pick: first set request at or after ptr+1, wrapping, so ptr itself has lowest priority
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             valid,
  output logic [SEL_W-1:0] idx
);
  logic [SEL_W-1:0] start;
  logic [N_REQ-1:0] rot;
  assign start = ptr + SEL_W'(1);
  assign rot = N_REQ'({req, req} >> start);
  assign valid = |req;
  assign idx = start + lowest_set(rot);
endmodule

// File: rtl/mux16_rr_arbiter.sv
// mux16_rr_arbiter: burst-limited round-robin owner of a shared 16:1 mux with registered, valid-qualified output
module mux16_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int BURST_MAX = 4,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] d,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             y,
  output logic             y_valid
);
  if (BURST_MAX < 1 || BURST_MAX > 15) begin : g_bad_burst
    $error("BURST_MAX must be in 1..15");
  end
  if ((1 << CNT_W) <= BURST_MAX) begin : g_bad_cnt
    $error("CNT_W too narrow for BURST_MAX");
  end
  state_t state, state_d;
  logic [N_REQ-1:0] gnt_d;
  logic [SEL_W-1:0] sel_d, ptr, ptr_d, pidx;
  logic [CNT_W-1:0] beat, beat_d;
  logic y_d, pv, beat_cyc, rel;
  rr_pick u_pick (.req(req), .ptr(ptr), .valid(pv), .idx(pidx));
  assign busy = state == GRANT;
  assign beat_cyc = busy && req[sel];
  assign rel = busy && (!req[sel] || beat == CNT_W'(BURST_MAX - 1));
  // ptr always equals sel during a grant, so one picker serves both IDLE and release
  always_comb begin
    state_d = state;
    gnt_d = gnt;
    sel_d = sel;
    ptr_d = ptr;
    beat_d = busy ? beat + CNT_W'(1) : beat;
    y_d = beat_cyc ? d[sel] : y;
    if (!busy || rel) begin
      state_d = pv ? GRANT : IDLE;
      gnt_d = pv ? onehot(pidx) : '0;
      sel_d = pv ? pidx : sel;
      ptr_d = pv ? pidx : ptr;
      beat_d = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt <= '0;
      sel <= '0;
      ptr <= SEL_W'(N_REQ - 1);
      beat <= '0;
      y <= 1'b0;
      y_valid <= 1'b0;
    end else begin
      state <= state_d;
      gnt <= gnt_d;
      sel <= sel_d;
      ptr <= ptr_d;
      beat <= beat_d;
      y <= y_d;
      y_valid <= beat_cyc;
    end
  end
endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// tb_mux16_rr_arbiter: random and directed checks of two arbiter instances (BURST_MAX 4 and 1) against a behavioural model
module tb_mux16_rr_arbiter;
  localparam int BM [2] = '{4, 1};
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] req = '0;
  logic [15:0] d = '0;
  logic [15:0] gnt_o [2];
  logic [3:0] sel_o [2];
  logic busy_o [2];
  logic y_o [2];
  logic yv_o [2];
  int checks = 0;
  int errors = 0;
  int owner [2];
  int mptr [2];
  int beats [2];
  int lsel [2];
  logic my [2];
  logic myv [2];
  bit seen_rst = 0;

  always #5 clk = ~clk;

  mux16_rr_arbiter #(.BURST_MAX(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .req(req), .d(d), .gnt(gnt_o[0]), .sel(sel_o[0]),
    .busy(busy_o[0]), .y(y_o[0]), .y_valid(yv_o[0])
  );
  mux16_rr_arbiter #(.BURST_MAX(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .d(d), .gnt(gnt_o[1]), .sel(sel_o[1]),
    .busy(busy_o[1]), .y(y_o[1]), .y_valid(yv_o[1])
  );

  task automatic chk(input string n, input int k, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h at %0t", n, k, a, e, $time);
    end
  endtask

  function automatic int pick(input logic [15:0] r, input int p);
    for (int s = 1; s <= 16; s++) if (r[(p + s) % 16]) return (p + s) % 16;
    return -1;
  endfunction

  // model: owner index (-1 idle), beats served in the current grant, last granted index
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit rel;
      int w;
      if (!rst_n) begin
        seen_rst = 1;
        owner[k] = -1;
        mptr[k] = 15;
        beats[k] = 0;
        lsel[k] = 0;
        my[k] = 1'b0;
        myv[k] = 1'b0;
      end else begin
        myv[k] = 1'b0;
        rel = owner[k] < 0;
        if (owner[k] >= 0) begin
          if (req[owner[k]]) begin
            my[k] = d[owner[k]];
            myv[k] = 1'b1;
            beats[k]++;
            rel = beats[k] == BM[k];
          end else rel = 1;
        end
        if (rel) begin
          w = pick(req, mptr[k]);
          owner[k] = w;
          beats[k] = 0;
          if (w >= 0) begin
            mptr[k] = w;
            lsel[k] = w;
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (seen_rst) begin
      for (int k = 0; k < 2; k++) begin
        chk("gnt", k, 32'(gnt_o[k]), owner[k] < 0 ? 32'h0 : 32'h1 << owner[k]);
        chk("sel", k, 32'(sel_o[k]), 32'(lsel[k]));
        chk("busy", k, 32'(busy_o[k]), 32'(owner[k] >= 0));
        chk("y_valid", k, 32'(yv_o[k]), 32'(myv[k]));
        chk("y", k, 32'(y_o[k]), 32'(my[k]));
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int cnt;
    logic [15:0] dv;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    req = 16'h0001;
    d = 16'h0001;
    @(negedge clk);
    chk("lit_rst_gnt", 0, 32'(gnt_o[0]), 32'h0001);
    chk("lit_rst_sel", 0, 32'(sel_o[0]), 32'h0);
    chk("lit_rst_yv", 0, 32'(yv_o[0]), 32'h0);
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      cnt += int'(yv_o[0] && y_o[0]);
    end
    chk("lit_burst4", 0, 32'(cnt), 32'd4);
    chk("lit_regrant0", 0, 32'(gnt_o[0]), 32'h0001);
    do_reset();
    req = 16'h8001;
    d = 16'($urandom);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("lit_alt_sel", 0, 32'(sel_o[0]), ((i / 4) % 2) != 0 ? 32'd15 : 32'd0);
      if (i > 0) chk("lit_alt_yv", 0, 32'(yv_o[0]), 32'h1);
    end
    do_reset();
    req = 16'hFFFF;
    dv = 16'($urandom);
    d = dv;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      chk("lit_step_sel", 1, 32'(sel_o[1]), 32'(i % 16));
      if (i > 0) begin
        chk("lit_step_yv", 1, 32'(yv_o[1]), 32'h1);
        chk("lit_step_y", 1, 32'(y_o[1]), 32'(dv[(i - 1) % 16]));
      end
    end
    do_reset();
    req = 16'h0208;
    @(negedge clk);
    chk("lit_drop_gnt3", 0, 32'(gnt_o[0]), 32'h0008);
    repeat (2) begin
      @(negedge clk);
      chk("lit_drop_yv", 0, 32'(yv_o[0]), 32'h1);
    end
    req = 16'h0200;
    @(negedge clk);
    chk("lit_drop_yv0", 0, 32'(yv_o[0]), 32'h0);
    chk("lit_drop_gnt9", 0, 32'(gnt_o[0]), 32'h0200);
    do_reset();
    req = 16'h0020;
    @(negedge clk);
    chk("lit_mid_gnt5", 0, 32'(gnt_o[0]), 32'h0020);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("lit_mid_gnt", 0, 32'(gnt_o[0]), 32'h0);
    chk("lit_mid_busy", 0, 32'(busy_o[0]), 32'h0);
    chk("lit_mid_yv", 0, 32'(yv_o[0]), 32'h0);
    rst_n = 1'b1;
    req = 16'h0024;
    @(negedge clk);
    chk("lit_mid_gnt2", 0, 32'(gnt_o[0]), 32'h0004);
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rst_n = $urandom_range(0, 199) != 0;
      if ($urandom_range(0, 3) == 0) req = 16'($urandom & $urandom);
      if ($urandom_range(0, 15) == 0) req = '0;
      d = 16'($urandom);
    end
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mux16_rr_arbiter.md
Name: mux16_rr_arbiter

Overview:
- Round-robin arbiter and sequencer for a shared 16:1 one-bit mux.
- Up to 16 requesters compete for the mux. The arbiter grants one requester at a time and drives the 4-bit select.
- For each cycle of a grant, it captures the selected data bit and presents it as a registered, valid-qualified output.
- Grants are bounded by a burst limit so that no requester can starve the others.

Parameters:
- BURST_MAX, default 4: maximum beats per grant. Legal range is 1..15. Any other value is an elaboration error.
- CNT_W, default 4: width of the beat counter. It must satisfy 2^CNT_W > BURST_MAX.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- req  input  16  per-requester request; requester i holds req[i] high while it wants the mux.
- d  input  16  per-requester data bit (mux data inputs).
- gnt  output  16  one-hot grant, or all zero when idle; registered.
- sel  output  4  mux select = index of the granted requester; registered; holds its last value when idle.
- busy  output  1  high while in GRANT state.
- y  output  1  registered mux output, d[sel] captured on a beat cycle.
- y_valid  output  1  y is valid this cycle.

Behaviour:
- Reset: one clock, synchronous, active-low. The reset port is rst_n. While rst_n=0 at a rising edge:
  - gnt=0, sel=0, busy=0, y=0, y_valid=0.
  - State = IDLE, beat counter = 0.
  - Last-grant pointer ptr = 15, so the first search starts at index 0.
  - Reset asserted mid-burst aborts the burst. Nothing is remembered.
- Round-robin pick (combinational):
  - Search req for the first set bit starting at index ptr+1, wrapping 15->0, and ending at ptr inclusive.
  - The most recently granted requester therefore has the lowest priority.
- State IDLE:
  - If req != 0: at the next edge set gnt=onehot(pick), sel=pick, ptr=pick, busy=1, beat=0, then go to GRANT.
  - Otherwise remain in IDLE with gnt=0.
- State GRANT, beat cycle (req[sel]=1):
  - Next edge: y=d[sel], y_valid=1.
  - If beat==BURST_MAX-1, this is the last beat and the grant is released. Otherwise beat increments and the grant holds.
- State GRANT, drop cycle (req[sel]=0):
  - Not a beat. Next edge: y_valid=0, grant released.
- Release:
  - Same edge: re-pick using ptr=sel, with the requester being released included at lowest priority.
  - If any req is set, gnt/sel move directly to the new winner with no idle cycle, and beat=0.
  - Otherwise gnt=0, busy=0, go to IDLE.
  - A requester whose burst expired is re-granted only if no other requester is asking.
- Latency:
  - req rise seen in IDLE at edge k -> gnt at k+1 -> first y_valid at k+2, carrying d[sel] sampled in cycle k+1.
  - Maximum wait for any continuously requesting line: 15*BURST_MAX cycles after its request is first seen.
- Other outputs and signals:
  - y_valid=0 whenever the previous cycle was not a beat.
  - y holds its last value when y_valid=0.
  - gnt is always zero or one-hot.
  - sel equals the index of gnt whenever busy=1.
  - Changes to req for non-granted lines during a grant have no effect until release.

Decomposition:
- Package mux_arb_pkg holds:
  - N_REQ=16, SEL_W=4.
  - state enum {IDLE, GRANT}.
  - onehot/index helper functions.
- One natural sub-module, rr_pick. It is combinational and takes req[15:0] and ptr[3:0], and returns valid plus idx[3:0] via a rotate-and-priority-encode. It is instantiated once in the arbiter.

Test Plan:
- Reset then req=16'h0001 held constant, d[0]=1: gnt=0001 and sel=0 one cycle later. With BURST_MAX=4, y_valid is high for 4 cycles with y=1. The grant then re-issues to requester 0, since no other request is pending.
- req=16'h8001 held constant, BURST_MAX=4: grants alternate 0 (4 beats), 15 (4 beats), 0, ... with zero idle cycles between them and sel toggling 0/15.
- req=16'hFFFF held, BURST_MAX=1: sel steps 0,1,2,...,15,0 one per cycle. y_valid is high every cycle from the second grant cycle, and y follows d[sel] with 1-cycle delay.
- Requester 3 is granted and drops req[3] after 2 beats while req[9]=1: exactly 2 y_valid pulses occur, y_valid goes low for the drop cycle, and gnt moves to 0200 on the same edge.
- rst_n=0 for one cycle mid-burst of requester 5: at the next edge gnt=0, busy=0, y_valid=0. After release with req[5] and req[2] high, the first grant goes to requester 2, because ptr was reset to 15.
